// File: rtl/eth_tx_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arb_pkg
// Description : Shared types and constants for the eth_10g transmit arbiter.
//               Provides the arbiter state enum, the per-source statistics
//               counter width and the largest supported source count.
// Revision    : 1.0 - initial release
// ============================================================================
package eth_tx_arb_pkg;

    // Arbiter states: IDLE arbitrates, XFER forwards one whole frame.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Width of each per-source completed-packet counter.
    localparam int STATS_WIDTH = 32;

    // Largest source count the arbiter is designed for.
    localparam int MAX_SRC = 8;

endpackage : eth_tx_arb_pkg
`default_nettype wire

// File: rtl/eth_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : eth_rr_pick
// Description : Purely combinational round-robin picker. Selects the first
//               asserted request strictly after i_last_grant, scanning upward
//               modulo N_SRC. Indices at or above N_SRC are never produced.
// Ports       : i_req        - request vector, one bit per source
//               i_last_grant - index of the most recently granted source
//               o_grant      - one-hot pick (all zero when no request)
//               o_idx        - index of the pick (0 when no request)
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rr_pick #(
    parameter int N_SRC = 4,
    parameter int IDX_W = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [N_SRC-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx
);

    int         w_cand;
    logic [IDX_W-1:0] w_cand_idx;

    // Walk the offsets from the farthest to the nearest so that the nearest
    // requester after i_last_grant is the one that survives.
    always_comb begin
        o_grant    = '0;
        o_idx      = '0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int off = N_SRC; off >= 1; off--) begin
            w_cand     = (int'(i_last_grant) + off) % N_SRC;
            w_cand_idx = IDX_W'(w_cand);
            if (i_req[w_cand_idx]) begin
                o_grant             = '0;
                o_grant[w_cand_idx] = 1'b1;
                o_idx               = w_cand_idx;
            end
        end
    end

endmodule : eth_rr_pick
`default_nettype wire

// File: rtl/eth_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : eth_tx_arbiter
// Description : Packet-level round-robin arbiter sharing the 32-bit eth_10g
//               transmit AXI-Stream port between N_SRC sources. A granted
//               source owns the port until its tlast beat is accepted, so
//               frames never interleave. Data path is combinational.
// Ports       : i_clk / i_reset          - s00_axis_aclk, async active-high
//               i_src_enable             - per-source arbitration mask
//               s_axis_*                 - flattened source streams
//               m_axis_*                 - stream to the MAC
//               o_grant / o_busy         - one-hot grant, packet in flight
//               o_pkt_count              - per-source completed packets
// Options     : ETH_TX_ARB_STATS_EN - builds the 32-bit packet counters;
//               when undefined o_pkt_count is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_tx_arbiter
    import eth_tx_arb_pkg::*;
#(
    parameter int N_SRC      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [N_SRC-1:0]               i_src_enable,
    input  logic [N_SRC*DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [N_SRC*KEEP_WIDTH-1:0]    s_axis_tkeep,
    input  logic [N_SRC-1:0]               s_axis_tvalid,
    input  logic [N_SRC-1:0]               s_axis_tlast,
    output logic [N_SRC-1:0]               s_axis_tready,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
    output logic                           m_axis_tvalid,
    output logic                           m_axis_tlast,
    input  logic                           m_axis_tready,
    output logic [N_SRC-1:0]               o_grant,
    output logic                           o_busy,
    output logic [N_SRC*STATS_WIDTH-1:0]   o_pkt_count
);

    localparam int IDX_W = $clog2(N_SRC);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [N_SRC-1:0] r_grant;
    logic [N_SRC-1:0] w_grant_nxt;
    logic [IDX_W-1:0] r_grant_idx;
    logic [IDX_W-1:0] w_grant_idx_nxt;
    logic [IDX_W-1:0] r_last_grant;
    logic [IDX_W-1:0] w_last_grant_nxt;
    logic [N_SRC-1:0] w_req;
    logic [N_SRC-1:0] w_pick_onehot;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_xfer;
    logic             w_hs_last;

    // The enable mask is only consulted here, so a packet already in flight
    // is never cut short by clearing its source's enable bit.
    assign w_req = s_axis_tvalid & i_src_enable;

    eth_rr_pick #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_grant      (w_pick_onehot),
        .o_idx        (w_pick_idx)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_grant_idx  <= '0;
            // Starting at the top index makes source 0 the first winner.
            r_last_grant <= IDX_W'(N_SRC - 1);
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_grant_idx  <= w_grant_idx_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_idx_nxt  = r_grant_idx;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt      = XFER;
                    w_grant_nxt      = w_pick_onehot;
                    w_grant_idx_nxt  = w_pick_idx;
                    w_last_grant_nxt = w_pick_idx;
                end
            end
            XFER: begin
                if (w_hs_last) begin
                    w_state_nxt = IDLE;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // Outputs depend only on state and live inputs, so an asynchronous reset
    // drops them in the same cycle it is asserted.
    assign w_xfer        = (r_state == XFER);
    assign o_busy        = w_xfer;
    assign o_grant       = r_grant;
    // r_grant is all-zero outside XFER, which gates readies and valid.
    assign s_axis_tready = r_grant & {N_SRC{m_axis_tready}};
    assign m_axis_tvalid = |(r_grant & s_axis_tvalid);
    assign m_axis_tdata  = w_xfer ? s_axis_tdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH]
                                  : '0;
    assign m_axis_tkeep  = w_xfer ? s_axis_tkeep[r_grant_idx*KEEP_WIDTH +: KEEP_WIDTH]
                                  : '0;
    assign m_axis_tlast  = w_xfer ? s_axis_tlast[r_grant_idx] : 1'b0;
    assign w_hs_last     = m_axis_tvalid & m_axis_tready & m_axis_tlast;

`ifdef ETH_TX_ARB_STATS_EN
    logic [N_SRC*STATS_WIDTH-1:0] r_pkt_cnt;

    // Counters wrap naturally from all-ones to zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pkt_cnt <= '0;
        end else if (w_hs_last) begin
            for (int k = 0; k < N_SRC; k++) begin
                if (r_grant[k]) begin
                    r_pkt_cnt[k*STATS_WIDTH +: STATS_WIDTH] <=
                        r_pkt_cnt[k*STATS_WIDTH +: STATS_WIDTH] + STATS_WIDTH'(1);
                end
            end
        end
    end

    assign o_pkt_count = r_pkt_cnt;
`else
    assign o_pkt_count = '0;
`endif

endmodule : eth_tx_arbiter
`default_nettype wire

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Packet-level round-robin arbiter that shares the single 32-bit transmit AXI-Stream port of `eth_10g` between `N_SRC` packet sources, such as generators and test-packet engines. Once a source is granted, it holds the port until its `tlast` beat completes, so frames are never interleaved. The block sits in the `s00_axis_aclk` domain, directly in front of the MAC transmit interface.

## Interface
- `N_SRC`, default 4: number of requesting sources, 2..8.
- `DATA_WIDTH`, default 32: AXIS data width; `KEEP_WIDTH = DATA_WIDTH/8`.
- `i_clk`, input, 1: transmit AXIS clock (`s00_axis_aclk`).
- `i_reset`, input, 1: reset, asynchronous and active-high.
- `i_src_enable`, input, `N_SRC`: per-source enable mask; a cleared bit means the source is never granted.
- `s_axis_tdata`, input, `N_SRC*DATA_WIDTH`: source data, flattened with source k at `[k*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tkeep`, input, `N_SRC*KEEP_WIDTH`: source byte enables, flattened the same way.
- `s_axis_tvalid`, input, `N_SRC`: per-source valid.
- `s_axis_tlast`, input, `N_SRC`: per-source last.
- `s_axis_tready`, output, `N_SRC`: per-source ready.
- `m_axis_tdata`, output, `DATA_WIDTH`: data to the MAC.
- `m_axis_tkeep`, output, `KEEP_WIDTH`: byte enables to the MAC.
- `m_axis_tvalid`, output, 1: valid to the MAC.
- `m_axis_tlast`, output, 1: last to the MAC.
- `m_axis_tready`, input, 1: ready from the MAC.
- `o_grant`, output, `N_SRC`: one-hot current grant; all zero when idle.
- `o_busy`, output, 1: high while a packet is in flight.
- `o_pkt_count`, output, `N_SRC*32`: completed packets per source (see Configuration).

## Operation
- FSM has two states: IDLE and XFER.
- IDLE: the request vector is `s_axis_tvalid & i_src_enable`.
  - If the request vector is non-zero, pick the first requester strictly after `last_grant`, scanning upward modulo `N_SRC`.
  - Register the choice into `grant` and `last_grant`, then go to XFER.
  - If the request vector is zero, stay in IDLE.
- XFER:
  - `m_axis_*` is driven by source `grant`.
  - `s_axis_tready[grant] = m_axis_tready`; all other readies are 0.
  - On `m_axis_tvalid & m_axis_tready & m_axis_tlast`: clear `grant` and go to IDLE.
- Clearing `i_src_enable` for the granted source mid-packet does not abort the packet; the mask applies only at the next arbitration.
- A granted source deasserting `tvalid` mid-packet stalls the port. The grant is held; there is no timeout.
- When `N_SRC` is not a power of two, the modulo scan skips indices at or above `N_SRC`.

## Timing
- Reset values:
  - state = IDLE
  - `last_grant = N_SRC-1`, so source 0 wins first
  - `o_grant = 0`, `o_busy = 0`
  - `m_axis_tvalid = 0`, `s_axis_tready = 0`
  - `m_axis_tdata`/`tkeep`/`tlast = 0`
  - counters = 0
- Data path is combinational when granted: zero cycles of latency from `s_axis_*` to `m_axis_*`.
- `s_axis_tready` is combinational from `m_axis_tready`.
- `m_axis_tvalid = (state==XFER) & s_axis_tvalid[grant]`. `m_axis_tdata`/`tkeep`/`tlast` are forced to 0 when not in XFER.
- Arbitration takes 1 cycle. There is exactly 1 dead cycle (IDLE) between a `tlast` handshake and the next packet's first beat.
- `o_busy = (state==XFER)`.
- Reset asserted mid-packet: all outputs take their reset values immediately (asynchronously). The partial frame is the MAC's problem, and the bench must tolerate it.

## Configuration
- Macro: `ETH_TX_ARB_STATS_EN`.
- Defined: one 32-bit counter per source, incremented on that source's `tlast` handshake. The counter wraps from `0xFFFFFFFF` to 0.
- Undefined: `o_pkt_count` is tied to 0 and no counter flops are built.

## Structure
- Package `eth_tx_arb_pkg` holds:
  - the state enum (IDLE, XFER)
  - the `STATS_WIDTH = 32` constant
  - the `MAX_SRC = 8` constant
- Sub-module `eth_rr_pick`: purely combinational round-robin picker. Inputs are the request vector and `last_grant`; outputs are a one-hot grant and its index.

## Test plan
- Single source: source 0 sends 4-beat packets with `m_axis_tready = 1`. Expect `m_axis` to mirror source 0, `o_grant = 4'b0001`, a 1-cycle gap between packets, and `o_pkt_count[0]` to increment per packet.
- Fairness: all 4 sources continuously valid, 3-beat packets. Expect grant order 0,1,2,3,0,…, no interleaving within any packet, and equal counts (±1) after 100 packets.
- Backpressure: toggle `m_axis_tready` 1-in-3 during a 6-beat packet from source 2. Expect only `s_axis_tready[2]` to follow `m_axis_tready`, and all 6 beats delivered in order.
- Mask: clear `i_src_enable[1]` while source 1 is mid-packet. Expect that packet to complete, after which source 1 is skipped (order 2,3,0,2,…).
- Reset mid-packet: assert `i_reset` on beat 2 of a source-3 packet. Expect `m_axis_tvalid`, `o_grant` and `o_busy` to go to 0 in the same cycle. After release, the first grant goes to source 0 if it requests.
- Stats wrap (with the macro defined): preload or force `o_pkt_count[0] = 0xFFFFFFFF` and send one packet. Expect the count to read 0.
